// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access; data has priority,
// a starvation counter forces fetch through. Optional perf counters: `define ARB_PERF_CNT_EN.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ok,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ok,
  output logic                data_stall,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_starve_cnt
`endif
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LAT_CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int STV_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [LAT_CW-1:0] lat_cnt_r, lat_cnt_nxt_s;
  logic [STV_W-1:0]  starve_cnt_r, starve_cnt_nxt_s;
  logic              idle_s, starved_s, lat_zero_s, grant_i_s, grant_d_s;

  // Grant decision; everything is suppressed while reset is asserted
  always_comb begin
    idle_s     = (state_r == IDLE) && !rst;
    starved_s  = (starve_cnt_r == STV_W'(STARVE_MAX));
    lat_zero_s = (lat_cnt_r == {LAT_CW{1'b0}});
    grant_d_s  = idle_s && data_req && !(inst_req && starved_s);
    grant_i_s  = idle_s && inst_req && !grant_d_s;
  end

  // FSM next state and read-latency countdown
  always_comb begin
    state_nxt_s   = state_r;
    lat_cnt_nxt_s = lat_cnt_r;
    case (state_r)
      IDLE: begin
        if (grant_d_s) begin
          state_nxt_s   = BUSY_D;
          lat_cnt_nxt_s = LAT_CW'(LAT - 1);
        end else if (grant_i_s) begin
          state_nxt_s   = BUSY_I;
          lat_cnt_nxt_s = LAT_CW'(LAT - 1);
        end else begin
          state_nxt_s   = IDLE;
          lat_cnt_nxt_s = {LAT_CW{1'b0}};
        end
      end
      BUSY_I, BUSY_D: begin
        if (lat_zero_s) begin
          state_nxt_s   = IDLE;
          lat_cnt_nxt_s = {LAT_CW{1'b0}};
        end else begin
          state_nxt_s   = state_r;
          lat_cnt_nxt_s = lat_cnt_r - LAT_CW'(1'b1);
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        lat_cnt_nxt_s = {LAT_CW{1'b0}};
      end
    endcase
  end

  // Fetch starvation tracking: counts data wins while fetch waits
  always_comb begin
    starve_cnt_nxt_s = starve_cnt_r;
    if (!inst_req || grant_i_s) begin
      starve_cnt_nxt_s = {STV_W{1'b0}};
    end else if (grant_d_s && !starved_s) begin
      starve_cnt_nxt_s = starve_cnt_r + STV_W'(1'b1);
    end else begin
      starve_cnt_nxt_s = starve_cnt_r;
    end
  end

  // Memory issue port and per-requester completion outputs
  always_comb begin
    mem_en     = grant_i_s || grant_d_s;
    mem_wen    = grant_d_s ? data_wen : {BE_W{1'b0}};
    mem_addr   = grant_d_s ? data_addr : (grant_i_s ? inst_addr : {ADDR_W{1'b0}});
    mem_wdata  = grant_d_s ? data_wdata : {DATA_W{1'b0}};
    inst_ok    = (state_r == BUSY_I) && lat_zero_s && !rst;
    data_ok    = (state_r == BUSY_D) && lat_zero_s && !rst;
    inst_rdata = inst_ok ? mem_rdata : {DATA_W{1'b0}};
    data_rdata = data_ok ? mem_rdata : {DATA_W{1'b0}};
    inst_stall = inst_req && !inst_ok;
    data_stall = data_req && !data_ok;
  end

  // State, latency and starvation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      lat_cnt_r    <= {LAT_CW{1'b0}};
      starve_cnt_r <= {STV_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_conflict_r, perf_starve_r;
  logic        conflict_s, force_i_s;

  assign conflict_s = idle_s && inst_req && data_req;
  assign force_i_s  = conflict_s && starved_s;

  // Wrapping event counters for contention and forced fetch grants
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_r <= 32'd0;
      perf_starve_r   <= 32'd0;
    end else begin
      perf_conflict_r <= conflict_s ? perf_conflict_r + 32'd1 : perf_conflict_r;
      perf_starve_r   <= force_i_s ? perf_starve_r + 32'd1 : perf_starve_r;
    end
  end

  assign perf_conflict_cnt = perf_conflict_r;
  assign perf_starve_cnt   = perf_starve_r;
`endif

endmodule
